// File: rtl/pipe_adder_tree.sv
// Elastic, pipelined multi-operand adder: reduces NUM_INPUTS masked, sign/zero-extended
// lanes to one full-precision sum, with a register stage every PIPE_EVERY tree levels.
module pipe_adder_tree #(
    parameter int NUM_INPUTS = 8,
    parameter int IN_WIDTH   = 25,
    parameter int OUT_WIDTH  = IN_WIDTH + $clog2(NUM_INPUTS),
    parameter int PIPE_EVERY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]          in_mask,
    input  logic                           in_signed,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [OUT_WIDTH-1:0]           out_sum,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int STAGES = (LEVELS == 0) ? 1 : (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

    function automatic int level_nodes(input int lvl);
        return (NUM_INPUTS + (1 << lvl) - 1) >> lvl;
    endfunction

    // A single-lane tree has no adder levels, so its only register sits on the entry level.
    function automatic int is_reg_level(input int lvl);
        if (LEVELS == 0) begin
            return (lvl == 0) ? 1 : 0;
        end else if (lvl == 0) begin
            return 0;
        end else if (((lvl % PIPE_EVERY) == 0) || (lvl == LEVELS)) begin
            return 1;
        end else begin
            return 0;
        end
    endfunction

    function automatic int stage_of(input int lvl);
        if (lvl == 0) begin
            return 0;
        end else begin
            return (lvl + PIPE_EVERY - 1) / PIPE_EVERY - 1;
        end
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] ld_s;
    logic [STAGES-1:0] vin_s;

    // Load enables ripple back from out_ready; an empty stage always loads (bubble collapse).
    always_comb begin
        logic take_s;
        take_s = out_ready;
        ld_s   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            take_s  = !v_q[k] || take_s;
            ld_s[k] = take_s;
        end
    end

    // Next-state valid bits: a loading stage takes the valid of the stage feeding it.
    always_comb begin
        vin_s    = '0;
        v_d      = v_q;
        vin_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vin_s[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (ld_s[k]) begin
                v_d[k] = vin_s[k];
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Stage valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int NL = level_nodes(l);
        logic [OUT_WIDTH-1:0] comb_s [NL];
        logic [OUT_WIDTH-1:0] src_s  [NL];

        if (l == 0) begin : g_ext
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
                logic [IN_WIDTH-1:0]  lane_s;
                logic [OUT_WIDTH-1:0] ext_s;
                assign lane_s = in_data[i*IN_WIDTH +: IN_WIDTH] & {IN_WIDTH{in_mask[i]}};

                // Mask first, then widen so a masked lane contributes exactly zero.
                always_comb begin
                    if (in_signed) begin
                        ext_s = OUT_WIDTH'($signed(lane_s));
                    end else begin
                        ext_s = OUT_WIDTH'(lane_s);
                    end
                end
                assign comb_s[i] = ext_s;
            end
        end else begin : g_add
            localparam int NP = level_nodes(l - 1);
            for (genvar i = 0; i < NL; i++) begin : g_node
                if (2 * i + 1 < NP) begin : g_pair
                    assign comb_s[i] = g_lvl[l-1].src_s[2*i] + g_lvl[l-1].src_s[2*i+1];
                end else begin : g_pass
                    assign comb_s[i] = g_lvl[l-1].src_s[2*i];
                end
            end
        end

        if (is_reg_level(l) != 0) begin : g_reg
            localparam int K = stage_of(l);
            logic [OUT_WIDTH-1:0] data_q [NL];

            // Stage data register; only updates when a valid beat moves in.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NL; i++) begin
                        data_q[i] <= '0;
                    end
                end else if (ld_s[K] && vin_s[K]) begin
                    data_q <= comb_s;
                end
            end
            assign src_s = data_q;
        end else begin : g_wire
            assign src_s = comb_s;
        end
    end

    assign in_ready  = ld_s[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = g_lvl[LEVELS].src_s[0];
    assign busy      = |v_q;

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Scoreboard bench for pipe_adder_tree: random and directed beats against an arithmetic
// reference model, plus small-configuration instances for odd lane counts and a single lane.
module tb_pipe_adder_tree;

    localparam int N  = 8;
    localparam int IW = 25;
    localparam int OW = 28;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*IW-1:0] in_data;
    logic [N-1:0]    in_mask;
    logic            in_signed;
    logic            in_valid;
    logic            in_ready;
    logic [OW-1:0]   out_sum;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    logic [39:0] s5_data;
    logic [4:0]  s5_mask;
    logic        s5_signed, s5_valid, s5_in_ready, s5_out_valid, s5_busy;
    logic [10:0] s5_sum;
    logic [7:0]  s1_data;
    logic [0:0]  s1_mask;
    logic        s1_signed, s1_valid, s1_in_ready, s1_out_valid, s1_busy;
    logic [7:0]  s1_sum;

    int checks   = 0;
    int failures = 0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] mon_exp;

    always #5 clk = ~clk;

    pipe_adder_tree #(.NUM_INPUTS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .PIPE_EVERY(1)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask), .in_signed(in_signed),
        .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    pipe_adder_tree #(.NUM_INPUTS(5), .IN_WIDTH(8), .PIPE_EVERY(2)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(s5_data), .in_mask(s5_mask), .in_signed(s5_signed),
        .in_valid(s5_valid), .in_ready(s5_in_ready), .out_sum(s5_sum), .out_valid(s5_out_valid),
        .out_ready(1'b1), .busy(s5_busy)
    );

    pipe_adder_tree #(.NUM_INPUTS(1), .IN_WIDTH(8), .PIPE_EVERY(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(s1_data), .in_mask(s1_mask), .in_signed(s1_signed),
        .in_valid(s1_valid), .in_ready(s1_in_ready), .out_sum(s1_sum), .out_valid(s1_out_valid),
        .out_ready(1'b1), .busy(s1_busy)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain integer sum of the included lanes, reduced modulo 2^OW.
    function automatic logic [OW-1:0] model(input logic [N*IW-1:0] d, input logic [N-1:0] m,
                                            input logic s);
        longint acc;
        longint v;
        logic [IW-1:0] lane;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            lane = d[i*IW +: IW];
            v = longint'(lane);
            if (s && lane[IW-1]) v = v - (longint'(1) << IW);
            if (m[i]) acc = acc + v;
        end
        return acc[OW-1:0];
    endfunction

    function automatic logic [N*IW-1:0] rand_data();
        logic [N*IW-1:0] d;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       d[i*IW +: IW] = {IW{1'b1}};
                1:       d[i*IW +: IW] = {1'b1, {(IW-1){1'b0}}};
                2:       d[i*IW +: IW] = IW'($urandom_range(0, 15));
                default: d[i*IW +: IW] = IW'($urandom);
            endcase
        end
        return d;
    endfunction

    // Monitor: pops on each output transfer; while stalled the head must already be on out_sum.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_spurious: out_valid=1 with no beat outstanding, out_sum=%0h", out_sum);
            end else if (out_ready) begin
                mon_exp = exp_q.pop_front();
                chk("out_sum", out_sum, mon_exp);
            end else begin
                chk("out_sum_stalled", out_sum, exp_q[0]);
            end
        end
    end

    task automatic send(input logic [N*IW-1:0] d, input logic [N-1:0] m, input logic s);
        int   guard;
        logic acc;
        in_data = d; in_mask = m; in_signed = s; in_valid = 1'b1;
        guard = 0; acc = 1'b0;
        while (!acc && guard < 200) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; guard++;
        end
        chk("send_accepted", acc, 1);
        if (acc) exp_q.push_back(model(d, m, s));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk); chk("drain_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    // Expects an empty pipe: the beat must surface exactly three edges after acceptance.
    task automatic latency_beat(input logic [N*IW-1:0] d, input logic [N-1:0] m, input logic s);
        out_ready = 1'b1;
        send(d, m, s);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_after_1", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_after_2", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_after_3", out_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic small_beat(input logic [39:0] d5, input logic [4:0] m5, input logic sg5,
                              input logic [10:0] exp5, input logic [7:0] d1, input logic m1,
                              input logic sg1, input logic [7:0] exp1);
        s5_data = d5; s5_mask = m5; s5_signed = sg5; s5_valid = 1'b1;
        s1_data = d1; s1_mask = m1; s1_signed = sg1; s1_valid = 1'b1;
        @(negedge clk);
        chk("n5_in_ready", s5_in_ready, 1);
        chk("n1_in_ready", s1_in_ready, 1);
        @(posedge clk); #1;
        s5_valid = 1'b0; s1_valid = 1'b0;
        @(negedge clk);
        chk("n5_valid_after_1", s5_out_valid, 0);
        chk("n1_valid_after_1", s1_out_valid, 1);
        chk("n1_sum", s1_sum, exp1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n5_valid_after_2", s5_out_valid, 1);
        chk("n5_sum", s5_sum, exp5);
        chk("n1_valid_after_2", s1_out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*IW-1:0] d;
        logic            acc;
        int              acc_cnt;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_signed = 1'b0; out_ready = 1'b1;
        s5_data = '0; s5_mask = '0; s5_signed = 1'b0; s5_valid = 1'b0;
        s1_data = '0; s1_mask = '0; s1_signed = 1'b0; s1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_in_ready", in_ready, 1);
        in_data = rand_data(); in_mask = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_capture_busy", busy, 0);
        chk("rst_no_capture_valid", out_valid, 0);
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) d[i*IW +: IW] = IW'(i + 1);
        latency_beat(d, 8'hFF, 1'b1);
        drain();

        out_ready = 1'b1;
        for (int i = 0; i < N; i++) d[i*IW +: IW] = 25'h1000000;
        send(d, 8'hFF, 1'b1);
        send(d, 8'hFF, 1'b0);
        for (int i = 0; i < N; i++) d[i*IW +: IW] = IW'(10 * (i + 1));
        send(d, 8'h0F, 1'b1);
        send(d, 8'h00, 1'b1);
        for (int i = 0; i < N; i++) d[i*IW +: IW] = {IW{1'b1}};
        send(d, 8'hFF, 1'b0);
        send(d, 8'hFF, 1'b1);
        drain();

        // Back-to-back stream with a 5-cycle downstream stall once the pipe is full.
        for (int b = 0; b < 10; b++) send(rand_data(), 8'($urandom), 1'($urandom));
        out_ready = 1'b0;
        in_data = rand_data();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int b = 0; b < 10; b++) send(rand_data(), 8'($urandom), 1'($urandom));
        drain();

        for (int c = 0; c < 300; c++) begin
            d = rand_data();
            in_data = d; in_mask = 8'($urandom); in_signed = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(model(d, in_mask, in_signed));
            #1;
        end
        drain();

        // From empty with out_ready low, exactly one beat per stage is accepted.
        out_ready = 1'b0; acc_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            d = rand_data();
            in_data = d; in_mask = 8'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
            @(negedge clk); acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(d, in_mask, in_signed));
                acc_cnt++;
            end
            #1;
        end
        chk("fill_accepts", acc_cnt, 3);
        chk("fill_busy", busy, 1);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_in_ready", in_ready, 0);

        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_sum", out_sum, 0);
        chk("arst_in_ready", in_ready, 1);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        latency_beat(rand_data(), 8'($urandom), 1'($urandom));
        drain();

        small_beat({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5'h1F, 1'b0, 11'd15, 8'h80, 1'b1, 1'b1, 8'h80);
        small_beat({5{8'hFF}}, 5'h1F, 1'b1, 11'h7FB, 8'h7F, 1'b0, 1'b1, 8'h00);
        small_beat({5{8'hFF}}, 5'h1F, 1'b0, 11'h4FB, 8'hC3, 1'b1, 1'b0, 8'hC3);
        small_beat({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5'h15, 1'b0, 11'd9, 8'hFF, 1'b1, 1'b1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
